// File: rtl/nibble_right_shifter.sv
// nibble_right_shifter
//   Receive-side inverse of the shift_cntrl-coded left shifter. It extracts an
//   OUT_W-bit field from a 2*OUT_W-bit packed word by right-shifting it 0, STEP
//   or 2*STEP bits. The shift runs iteratively, STEP bits per clock. Any set bit
//   outside the extracted window is reported on lost_bits.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   in_valid/ready  input handshake for shift_in/shift_cntrl
//   shift_in        packed word (2*OUT_W bits)
//   shift_cntrl     00/11: shift 0, 01: shift STEP, 10: shift 2*STEP
//   out_valid/ready output handshake for shift_out/lost_bits
//   shift_out       extracted field (0 while out_valid=0)
//   lost_bits       a nonzero bit lay outside the window (0 while out_valid=0)
//   busy            1 in any state other than IDLE
//   state_dbg       current FSM state (IDLE=0, SHIFT=1, DONE=2)
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. The input side is ready only in IDLE, so one word is in flight at a time.
// The output holds shift_out/lost_bits stable in DONE until out_ready is seen.
module nibble_right_shifter #(
  parameter int OUT_W = 8,
  parameter int STEP  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*OUT_W-1:0] shift_in,
  input  logic [1:0]         shift_cntrl,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   shift_out,
  output logic               lost_bits,
  output logic               busy,
  output logic [1:0]         state_dbg
);

  localparam int IN_W = 2 * OUT_W;
  // Window of the unshifted field: low OUT_W bits set.
  localparam logic [IN_W-1:0] BASE_MASK = {{OUT_W{1'b0}}, {OUT_W{1'b1}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [IN_W-1:0]   data_q, data_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              lost_q, lost_d;

  logic [1:0]        cnt_in;
  logic [IN_W-1:0]   win_mask;
  logic              lost_in;

  // Decode the shift count. Code 11 is treated as "no shift", like 00.
  always_comb begin
    cnt_in   = 2'd0;
    win_mask = BASE_MASK;
    case (shift_cntrl)
      2'b01: begin
        cnt_in   = 2'd1;
        win_mask = BASE_MASK << STEP;
      end
      2'b10: begin
        cnt_in   = 2'd2;
        win_mask = BASE_MASK << (2 * STEP);
      end
      default: begin
        cnt_in   = 2'd0;
        win_mask = BASE_MASK;
      end
    endcase
  end

  // The lost flag is computed once, from the word as it is captured, so later
  // zero-filling in SHIFT cannot hide or invent out-of-window bits.
  assign lost_in = |(shift_in & ~win_mask);

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    lost_d  = lost_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = shift_in;
          cnt_d   = cnt_in;
          lost_d  = lost_in;
          state_d = (cnt_in == 2'd0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        data_d = data_q >> STEP;
        cnt_d  = cnt_q - 2'd1;
        if (cnt_q == 2'd1) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= 2'd0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      lost_q  <= lost_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign shift_out = out_valid ? data_q[OUT_W-1:0] : '0;
  assign lost_bits = out_valid & lost_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_nibble_right_shifter.sv
module tb_nibble_right_shifter;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] shift_in;
  logic [1:0]  shift_cntrl;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  shift_out;
  logic        lost_bits;
  logic        busy;
  logic [1:0]  state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected response queue: {lost_bits, shift_out}
  logic [8:0] exp_q[$];

  nibble_right_shifter #(.OUT_W(8), .STEP(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .shift_in    (shift_in),
    .shift_cntrl (shift_cntrl),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .shift_out   (shift_out),
    .lost_bits   (lost_bits),
    .busy        (busy),
    .state_dbg   (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=0x%0h exp=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output act=0x%0h exp=none at %0t",
                   {lost_bits, shift_out}, $time);
        end else begin
          chk("result", {23'd0, lost_bits, shift_out}, {23'd0, exp_q.pop_front()});
        end
      end
      if (!out_valid) begin
        chk("idle_outputs_zero", {23'd0, lost_bits, shift_out}, 32'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge. Returns just after the accept edge.
  task automatic issue(input logic [15:0] w, input logic [1:0] c,
                       input logic [7:0] eo, input logic el);
    int guard;
    shift_in    = w;
    shift_cntrl = c;
    in_valid    = 1'b1;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout act=in_ready_low exp=in_ready_high");
    end
    exp_q.push_back({el, eo});
    @(posedge clk);
    #1;
    in_valid    = 1'b0;
    // Scramble the inputs: only the values captured at accept may matter.
    shift_in    = ~w;
    shift_cntrl = 2'b10;
  endtask

  // Counts clocks from the accept edge until out_valid; ends at a falling edge.
  task automatic check_lat(input string name, input int elat);
    int lat;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 10);
    chk(name, lat, elat);
  endtask

  task automatic send(input string name, input logic [15:0] w, input logic [1:0] c,
                      input logic [7:0] eo, input logic el, input int elat);
    issue(w, c, eo, el);
    check_lat(name, elat);
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] w;
    logic [1:0]  c;
    int          k;
    logic [15:0] mask;
    logic [15:0] shifted;
    logic [7:0]  eo;
    logic        el;

    rst         = 1'b1;
    in_valid    = 1'b0;
    shift_in    = 16'h0;
    shift_cntrl = 2'b00;
    out_ready   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_shift_out", shift_out, 0);
    chk("reset_lost_bits", lost_bits, 0);
    chk("reset_busy", busy, 0);
    @(posedge clk);
    #1;

    // 1-3: directed vectors, hand-computed results
    send("lat_shift0", 16'h00A5, 2'b00, 8'hA5, 1'b0, 1);
    issue(16'h0A50, 2'b01, 8'hA5, 1'b0);
    @(negedge clk);
    chk("busy_in_shift", busy, 1);
    chk("in_ready_in_shift", in_ready, 0);
    @(negedge clk);
    chk("lat_shift4_valid", out_valid, 1);
    @(posedge clk);
    #1;
    send("lat_shift8", 16'hA500, 2'b10, 8'hA5, 1'b0, 3);
    send("lat_cntrl11", 16'hA5FF, 2'b11, 8'hFF, 1'b1, 1);
    send("lat_lost4", 16'h8A51, 2'b01, 8'hA5, 1'b1, 2);
    send("lat_zero", 16'h0000, 2'b10, 8'h00, 1'b0, 3);
    send("lat_lost_hi", 16'h1234, 2'b00, 8'h34, 1'b1, 1);

    // 4: output stall with a competing in_valid
    out_ready = 1'b0;
    issue(16'h0A50, 2'b01, 8'hA5, 1'b0);
    check_lat("lat_stall", 2);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      in_valid    = 1'b1;
      shift_in    = 16'h00FF;
      shift_cntrl = 2'b00;
      @(negedge clk);
      chk("stall_valid", out_valid, 1);
      chk("stall_data", {23'd0, lost_bits, shift_out}, 32'h0A5);
      chk("stall_in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("after_hs_in_ready", in_ready, 1);
    chk("after_hs_out_valid", out_valid, 0);
    @(posedge clk);
    #1;

    // 5: reset aborts a word in SHIFT
    issue(16'hA500, 2'b10, 8'hA5, 1'b0);
    rst = 1'b1;
    void'(exp_q.pop_back());
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_busy", busy, 0);
    repeat (4) begin
      @(negedge clk);
      chk("abort_no_valid", out_valid, 0);
    end
    @(posedge clk);
    #1;
    send("lat_after_abort", 16'h00A5, 2'b00, 8'hA5, 1'b0, 1);

    // 6: back-to-back random words with random gaps
    for (int n = 0; n < 40; n++) begin
      w = 16'($urandom_range(0, 65535));
      c = 2'($urandom_range(0, 3));
      k = (c == 2'b01) ? 1 : (c == 2'b10) ? 2 : 0;
      shifted = w >> (4 * k);
      eo   = shifted[7:0];
      mask = 16'h00FF << (4 * k);
      el   = |(w & ~mask);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      send("lat_random", w, c, eo, el, k + 1);
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
